// File: rtl/pong_ball_engine.sv
// Ball physics and scoring engine for pong: one MOVE/CHECK step per accepted frame tick,
// with wall bounce, paddle hits with speed-up and hit-zone deflection, goals, re-serve and game-over.
module pong_ball_engine #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 10,
  parameter int PADDLE_W    = 10,
  parameter int PADDLE_H    = 50,
  parameter int P1_X        = 40,
  parameter int P2_X        = 600,
  parameter int SPD_W       = 4,
  parameter int INIT_SPEED  = 2,
  parameter int MAX_SPEED   = 8,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int PAUSE_TICKS = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               serve,
  input  logic [9:0]         p1_y,
  input  logic [9:0]         p2_y,
  output logic [10:0]        ball_x,
  output logic [9:0]         ball_y,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               goal,
  output logic               game_over,
  output logic               step_done,
  output logic [2:0]         state_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_MOVE  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  localparam logic [10:0] CENTER_X = 11'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]  CENTER_Y = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [11:0] X_MAX    = 12'(SCREEN_W - BALL_SIZE);
  localparam logic [11:0] Y_MAX    = 12'(SCREEN_H - BALL_SIZE);
  localparam logic [11:0] BS       = 12'(BALL_SIZE);
  localparam logic [11:0] HALF     = 12'(BALL_SIZE / 2);
  localparam logic [11:0] PH       = 12'(PADDLE_H);
  localparam logic [11:0] L_X      = 12'(P1_X);
  localparam logic [11:0] L_EDGE   = 12'(P1_X + PADDLE_W);
  localparam logic [11:0] R_X      = 12'(P2_X);
  localparam logic [11:0] R_EDGE   = 12'(P2_X + PADDLE_W);
  localparam logic [11:0] ZONE_LO  = 12'(PADDLE_H / 3);
  localparam logic [11:0] ZONE_HI  = 12'(2 * PADDLE_H / 3);
  localparam logic [10:0] L_STOP   = 11'(P1_X + PADDLE_W);
  localparam logic [10:0] R_STOP   = 11'(P2_X - BALL_SIZE);

  localparam logic [SPD_W-1:0]   SPD_INIT  = SPD_W'(INIT_SPEED);
  localparam logic [SPD_W-1:0]   SPD_MAX   = SPD_W'(MAX_SPEED);
  localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);
  localparam int unsigned        PC_W      = $clog2(PAUSE_TICKS + 1);
  localparam logic [PC_W-1:0]    PC_LAST   = PC_W'(PAUSE_TICKS - 1);

  logic [2:0]         state;
  logic [11:0]        nx, ny;
  logic [SPD_W-1:0]   spd_x, spd_y;
  logic               dir_x, dir_y;
  logic [PC_W-1:0]    pcnt;

  logic [11:0]        x_ext, y_ext, sx_ext, sy_ext;
  logic [11:0]        cy, p1_ext, p2_ext, hit_py, rel;
  logic [10:0]        cx;
  logic               c_dx, c_dy, hit_l, hit_r, goal_l, goal_r, win;
  logic [SPD_W-1:0]   c_spd;
  logic [SCORE_W-1:0] p1_inc, p2_inc;

  assign x_ext     = {1'b0, ball_x};
  assign y_ext     = {2'b0, ball_y};
  assign sx_ext    = 12'(spd_x);
  assign sy_ext    = 12'(spd_y);
  assign p1_ext    = {2'b0, p1_y};
  assign p2_ext    = {2'b0, p2_y};
  assign p1_inc    = p1_score + SCORE_W'(1);
  assign p2_inc    = p2_score + SCORE_W'(1);
  assign game_over = (state == S_OVER);
  assign state_o   = state;

  // Collision resolution for the pending step: walls, then paddles, then goals.
  always_comb begin
    cy    = ny;
    c_dy  = dir_y;
    cx    = nx[10:0];
    c_dx  = dir_x;
    c_spd = spd_x;
    if (ny == '0) begin
      c_dy = 1'b1;
    end else if (ny >= Y_MAX) begin
      cy   = Y_MAX;
      c_dy = 1'b0;
    end
    hit_l = !dir_x && (nx <= L_EDGE) && (nx + BS > L_X) &&
            (cy + BS > p1_ext) && (cy < p1_ext + PH);
    hit_r = dir_x && (nx + BS >= R_X) && (nx < R_EDGE) &&
            (cy + BS > p2_ext) && (cy < p2_ext + PH);
    hit_py = hit_l ? p1_ext : p2_ext;
    rel    = (cy + HALF < hit_py) ? '0 : cy + HALF - hit_py;
    if (hit_l || hit_r) begin
      cx    = hit_l ? L_STOP : R_STOP;
      c_dx  = hit_l;
      c_spd = (spd_x >= SPD_MAX) ? SPD_MAX : spd_x + SPD_W'(1);
      if (rel < ZONE_LO)
        c_dy = 1'b0;
      else if (rel >= ZONE_HI)
        c_dy = 1'b1;
    end
    goal_l = !(hit_l || hit_r) && (nx == '0);
    goal_r = !(hit_l || hit_r) && !goal_l && (nx >= X_MAX);
    win    = goal_r ? (p1_inc == SCORE_WIN) : (p2_inc == SCORE_WIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ball_x    <= CENTER_X;
      ball_y    <= CENTER_Y;
      nx        <= '0;
      ny        <= '0;
      spd_x     <= SPD_INIT;
      spd_y     <= SPD_INIT;
      dir_x     <= 1'b1;
      dir_y     <= 1'b0;
      pcnt      <= '0;
      p1_score  <= '0;
      p2_score  <= '0;
      goal      <= 1'b0;
      step_done <= 1'b0;
    end else begin
      goal      <= 1'b0;
      step_done <= 1'b0;
      case (state)
        S_IDLE: if (serve) state <= S_WAIT;
        S_WAIT: if (tick) state <= S_MOVE;
        S_MOVE: begin
          nx    <= dir_x ? x_ext + sx_ext : ((x_ext >= sx_ext) ? x_ext - sx_ext : '0);
          ny    <= dir_y ? y_ext + sy_ext : ((y_ext >= sy_ext) ? y_ext - sy_ext : '0);
          state <= S_CHECK;
        end
        S_CHECK: begin
          step_done <= 1'b1;
          if (goal_l || goal_r) begin
            goal   <= 1'b1;
            pcnt   <= '0;
            ball_x <= CENTER_X;
            ball_y <= CENTER_Y;
            spd_x  <= SPD_INIT;
            spd_y  <= SPD_INIT;
            dir_x  <= goal_r;
            dir_y  <= 1'b0;
            if (goal_r)
              p1_score <= p1_inc;
            else
              p2_score <= p2_inc;
            state <= win ? S_OVER : S_PAUSE;
          end else begin
            ball_x <= cx;
            ball_y <= cy[9:0];
            dir_x  <= c_dx;
            dir_y  <= c_dy;
            spd_x  <= c_spd;
            state  <= S_WAIT;
          end
        end
        S_PAUSE: if (tick) begin
          pcnt <= pcnt + PC_W'(1);
          if (pcnt == PC_LAST) begin
            dir_y <= 1'b0;
            state <= S_WAIT;
          end
        end
        S_OVER: if (serve) begin
          p1_score <= '0;
          p2_score <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
